// File: rtl/speaker_tone_gen.sv
// Distance-meter beeper: emits beeps of a fixed length whose tone pitch and
// silent-gap length both follow a 5-bit note value. Notes at or above
// SILENT_NOTE suppress the beep and the note is re-sampled periodically.
module speaker_tone_gen #(
  parameter int BEEP_ON_CYCLES  = 10_000_000,
  parameter int GAP_STEP_CYCLES = 5_000_000,
  parameter int TONE_BASE       = 25_000,
  parameter int TONE_STEP       = 1_000,
  parameter int SILENT_NOTE     = 31
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [4:0] note_in,
  input  logic       enable,
  output logic       speaker_out,
  output logic       beep_active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [27:0] BEEP_LAST = 28'(BEEP_ON_CYCLES - 1);
  localparam logic [27:0] HOLD_LAST = 28'(GAP_STEP_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  note_l;
  logic [27:0] phase_cnt;    // elapsed cycles in the current BEEP/GAP/HOLD phase
  logic [16:0] tone_cnt;     // position within the current tone half-period
  logic [16:0] half_period;
  logic [27:0] phase_last;
  logic        phase_done;
  logic        tone_wrap;
  logic        note_silent_in;
  logic        latch_note;
  logic        speaker_nxt;
  logic        beep_active_nxt;

  // Tone half-period and phase end point derived from the latched note only,
  // so note_in changes between latch points cannot disturb a running phase.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    phase_last  = '1;
    half_period = 17'(TONE_BASE) + 17'(note_l) * 17'(TONE_STEP);
    case (state)
      BEEP:    phase_last = BEEP_LAST;
      GAP:     phase_last = 28'(note_l) * 28'(GAP_STEP_CYCLES) - 28'd1;
      HOLD:    phase_last = HOLD_LAST;
      default: phase_last = '1;
    endcase
    phase_done     = (phase_cnt == phase_last);
    tone_wrap      = (tone_cnt == half_period - 17'd1);
    note_silent_in = (note_in >= 5'(SILENT_NOTE));
  end

  // State register.
  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; latch_note marks the cycles where note_in is sampled.
  always_comb begin
    state_nxt  = state;
    latch_note = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: latch_note = 1'b1;
        BEEP: begin
          if (phase_done) begin
            if (note_l == 5'd0) latch_note = 1'b1;  // zero-length gap: straight back
            else                state_nxt  = GAP;
          end
        end
        GAP:  latch_note = phase_done;
        HOLD: latch_note = phase_done;
        default: state_nxt = IDLE;
      endcase
      if (latch_note) state_nxt = note_silent_in ? HOLD : BEEP;
    end
  end

  // Output logic: next values of the registered speaker and beep flag.
  always_comb begin
    speaker_nxt = 1'b0;
    if (enable && state == BEEP && !phase_done)
      speaker_nxt = tone_wrap ? ~speaker_out : speaker_out;
    beep_active_nxt = (state_nxt == BEEP);
  end

  // Counters, latched note and output registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      note_l      <= '0;
      phase_cnt   <= '0;
      tone_cnt    <= '0;
      speaker_out <= 1'b0;
      beep_active <= 1'b0;
    end else begin
      speaker_out <= speaker_nxt;
      beep_active <= beep_active_nxt;
      if (latch_note) note_l <= note_in;
      if (!enable || state == IDLE || phase_done) begin
        phase_cnt <= '0;
        tone_cnt  <= '0;
      end else begin
        phase_cnt <= phase_cnt + 28'd1;
        tone_cnt  <= (state == BEEP && !tone_wrap) ? tone_cnt + 17'd1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_speaker_tone_gen.sv
// Bench for speaker_tone_gen with small parameters. A segment-level model
// (beep/gap/hold with an age counter and arithmetic tone phase) predicts both
// outputs every clock; directed scenarios are followed by random traffic.
module tb_speaker_tone_gen;

  localparam int BEEP_ON = 100;
  localparam int GAP_STEP = 50;
  localparam int T_BASE = 10;
  localparam int T_STEP = 2;
  localparam int SILENT = 31;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] note_in = 5'd0;
  logic       enable = 1'b0;
  logic       speaker_out;
  logic       beep_active;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;

  // Model: 0 = off, 1 = beep, 2 = gap, 3 = hold
  int m_seg = 0;
  int m_age = 0;
  int m_note = 0;

  speaker_tone_gen #(
    .BEEP_ON_CYCLES (BEEP_ON),
    .GAP_STEP_CYCLES(GAP_STEP),
    .TONE_BASE      (T_BASE),
    .TONE_STEP      (T_STEP),
    .SILENT_NOTE    (SILENT)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .note_in    (note_in),
    .enable     (enable),
    .speaker_out(speaker_out),
    .beep_active(beep_active)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic int seg_len(int seg, int note);
    case (seg)
      1: return BEEP_ON;
      2: return note * GAP_STEP;
      3: return GAP_STEP;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock given the inputs seen at that edge.
  task automatic model_step(input logic r, input logic e, input int n);
    if (r) begin
      m_seg = 0; m_age = 0; m_note = 0;
    end else if (!e) begin
      m_seg = 0; m_age = 0;
    end else if (m_seg == 0 || m_age == seg_len(m_seg, m_note) - 1) begin
      m_age = 0;
      if (m_seg == 1 && m_note != 0) begin
        m_seg = 2;
      end else begin
        m_note = n;
        m_seg  = (n >= SILENT) ? 3 : 1;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
  endtask

  // Apply inputs, clock once, update the model and compare both outputs.
  task automatic cyc(input logic r, input logic e, input int n);
    logic exp_spk;
    reset = r; enable = e; note_in = 5'(n);
    @(posedge clk_100MHz);
    cyc_no++;
    model_step(r, e, n);
    #1;
    exp_spk = (m_seg == 1) && (((m_age / (T_BASE + T_STEP * m_note)) % 2) == 1);
    check_bit("speaker_out", speaker_out, exp_spk);
    check_bit("beep_active", beep_active, m_seg == 1);
  endtask

  task automatic run(input logic e, input int n, input int count);
    for (int i = 0; i < count; i++) cyc(1'b0, e, n);
  endtask

  initial begin
    int n;
    logic e;
    logic r;

    // Reset state, enable low
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 5);  // reset wins over enable
    run(1'b0, 3, 5);

    // note 3: hp=16, beep 100, gap 150, next beep
    run(1'b1, 3, 600);

    // note changes mid-beep: current beep/gap keep note 3, then note 10
    cyc(1'b1, 1'b0, 0);
    run(1'b1, 3, 40);
    run(1'b1, 10, 1000);

    // enable dropped mid-beep, then re-enabled
    cyc(1'b1, 1'b0, 0);
    run(1'b1, 4, 57);
    run(1'b0, 4, 3);
    run(1'b1, 4, 60);

    // note 0: back-to-back beeps
    cyc(1'b1, 1'b0, 0);
    run(1'b1, 0, 320);

    // silent note holds, then note 2 starts a beep
    cyc(1'b1, 1'b0, 0);
    run(1'b1, 31, 120);
    run(1'b1, 2, 300);

    // one-cycle reset mid-gap with enable high
    cyc(1'b1, 1'b0, 0);
    run(1'b1, 3, 170);
    cyc(1'b1, 1'b1, 3);
    run(1'b1, 3, 60);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)       n = 31;
      else if ($urandom_range(0, 19) == 0) n = $urandom_range(0, 30);
      else                                 n = $urandom_range(0, 6);
      e = ($urandom_range(0, 399) != 0);
      r = ($urandom_range(0, 999) == 0);
      cyc(r, e, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
